rcv_multimode_counter: RTL and testbench
========================================

// Module: rcv_multimode_counter
// PURPOSE
//  Parametrised multi-mode counter; successor to the receiver's basic flex counter.
//  Adds up/down wrap, saturate and one-shot modes, synchronous load, a rollover pulse and a done flag.
//  Used by the USB receiver for bit-stuff, byte and timeout counting.
//  Also used by the SIE for packet-length and EOP timing.
// PARAMETERS
//  NUM_CNT_BITS   4  counter width; all count/value ports share this width.
//  PRESCALE_BITS  3  prescaler width; used only when CNT_PRESCALE_EN is defined.
// PORTS
//  clk            in   1            clock, rising edge
//  n_rst          in   1            reset, asynchronous, active-low
//  clear          in   1            synchronous clear; highest priority
//  load           in   1            synchronous load of load_val
//  count_enable   in   1            request one count step
//  mode           in   2            00 WRAP_UP, 01 WRAP_DOWN, 10 SAT_UP, 11 ONE_SHOT
//  load_val       in   NUM_CNT_BITS value loaded on load
//  rollover_val   in   NUM_CNT_BITS terminal/reload value
//  prescale_div   in   PRESCALE_BITS steps every prescale_div+1 enables (CNT_PRESCALE_EN only)
//  count_out      out  NUM_CNT_BITS current count, registered
//  rollover_flag  out  1            registered; high while count_out == terminal
//  rollover_pulse out  1            one-cycle pulse when a count step lands on terminal
//  done           out  1            ONE_SHOT finished; held until clear/load
// BEHAVIOUR
//  - Reset: count_out=0, rollover_flag=0, rollover_pulse=0, done=0, FSM=RUN, prescaler=0.
//  - Terminal value: rollover_val in the up modes (00/10/11); 1 in WRAP_DOWN.
//  - Priority is clear > load > step.
//    - clear: count_out=0, flag=0, pulse=0, done=0, FSM=RUN.
//    - load: count_out=load_val, flag=(load_val==terminal), pulse=0, done=0, FSM=RUN.
//  - A step occurs on a count_enable cycle with no clear or load, when FSM=RUN and rollover_val!=0.
//  - rollover_val==0: steps are suppressed; count_out holds; flag and pulse are 0.
//  - WRAP_UP:
//    - count_out >= rollover_val -> next count 1.
//    - otherwise -> count_out+1.
//    - Sequence is 0,1..R,1..R,...
//  - WRAP_DOWN:
//    - count_out <= 1 -> next count rollover_val.
//    - otherwise -> count_out-1.
//  - SAT_UP:
//    - count_out < rollover_val -> +1.
//    - otherwise hold; resumes if rollover_val is raised.
//  - ONE_SHOT:
//    - Counts up like SAT_UP.
//    - A step landing on rollover_val also sets FSM=DONE and done=1 in the same edge.
//    - In DONE, count_enable is ignored and count_out holds.
//    - Only clear or load exits DONE.
//  - rollover_flag:
//    - Updated on every count_out update (step/load/clear) to (next count == terminal).
//    - Holds otherwise; rollover_val changes while idle do not update it.
//  - rollover_pulse = 1 for exactly the cycle after a step where next==terminal and count_out!=terminal.
//    - A SAT_UP hold at terminal gives no pulse.
//  - mode changes take effect on the next step. Wrap arithmetic is modulo 2^NUM_CNT_BITS internally.
//  - No combinational path from inputs to outputs; all outputs change only on clk or n_rst.
//  - n_rst asserted mid-count forces the reset values immediately (asynchronous).
// CONFIGURATION
//  - CNT_PRESCALE_EN defined:
//    - Adds the prescale_div port and a PRESCALE_BITS prescaler.
//    - The prescaler increments on qualified count_enable cycles.
//    - A step fires when prescaler==prescale_div; the prescaler then returns to 0.
//    - clear and load zero the prescaler. prescale_div=0 gives a step on every enable.
//  - CNT_PRESCALE_EN undefined: no port, no prescaler; every qualified enable is a step.
// TESTING
//  - WRAP_UP, R=5, enable 12 cycles from reset:
//    - count 1,2,3,4,5,1,2,3,4,5,1,2.
//    - flag high while count==5; pulse after each arrival at 5.
//  - WRAP_DOWN, load 3, R=4, enable 6 cycles:
//    - count 2,1,4,3,2,1.
//    - flag high on each 1; pulse 2 times.
//  - SAT_UP, R=3, enable 6: count 1,2,3,3,3,3; one pulse; flag stays 1. Raise R to 5 -> 4,5.
//  - ONE_SHOT, R=2, enable 5:
//    - count 1,2 then holds 2; done=1 from the cycle count hits 2.
//    - load 0 -> done=0 and counting resumes.
//  - clear+load+enable in same cycle at count 4 -> count 0, flag 0, done 0. Then n_rst mid-count -> all outputs 0.
//  - CNT_PRESCALE_EN, prescale_div=2, WRAP_UP R=3, enable 9 cycles: count steps on enables 3,6,9 -> 1,2,3.

Source files
------------

// File: rtl/rcv_multimode_counter.sv
// Purpose: multi-mode counter (wrap up/down, saturate, one-shot) with load, rollover flag/pulse, done flag.
// Latency: all outputs registered; a step, load or clear is visible one clk after the qualifying cycle.
// Backpressure: none; count_enable is a request, ignored in DONE, when rollover_val==0 or while prescaling.
// Build option: define CNT_PRESCALE_EN to add prescale_div and a PRESCALE_BITS-wide step prescaler.
module rcv_multimode_counter #(
    parameter int NUM_CNT_BITS  = 4
`ifdef CNT_PRESCALE_EN
    ,
    parameter int PRESCALE_BITS = 3
`endif
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      clear,
    input  logic                      load,
    input  logic                      count_enable,
    input  logic [1:0]                mode,
    input  logic [NUM_CNT_BITS-1:0]   load_val,
    input  logic [NUM_CNT_BITS-1:0]   rollover_val,
`ifdef CNT_PRESCALE_EN
    input  logic [PRESCALE_BITS-1:0]  prescale_div,
`endif
    output logic [NUM_CNT_BITS-1:0]   count_out,
    output logic                      rollover_flag,
    output logic                      rollover_pulse,
    output logic                      done
);

    localparam logic [1:0] MODE_WRAP_UP   = 2'b00;
    localparam logic [1:0] MODE_WRAP_DOWN = 2'b01;
    localparam logic [1:0] MODE_ONE_SHOT  = 2'b11;
    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = NUM_CNT_BITS'(1);

    typedef enum logic {ST_RUN, ST_DONE} state_t;

    state_t                    state_q, state_d;
    logic [NUM_CNT_BITS-1:0]   count_q, count_d;
    logic                      flag_q, flag_d;
    logic                      pulse_q, pulse_d;
    logic [NUM_CNT_BITS-1:0]   terminal;
    logic [NUM_CNT_BITS-1:0]   step_val;
    logic                      step_qual;
    logic                      step_fire;

    // Down-counting wraps through 1, so its terminal is fixed; up modes end at rollover_val.
    assign terminal = (mode == MODE_WRAP_DOWN) ? CNT_ONE : rollover_val;

    // An enable only counts when nothing higher-priority is happening and a terminal exists.
    assign step_qual = count_enable && !clear && !load &&
                       (state_q == ST_RUN) && (rollover_val != '0);

`ifdef CNT_PRESCALE_EN
    logic [PRESCALE_BITS-1:0] presc_q, presc_d;

    // Prescaler: every (prescale_div+1)-th qualified enable becomes a step.
    always_comb begin
        presc_d   = presc_q;
        step_fire = 1'b0;
        if (clear || load) begin
            presc_d = '0;
        end else if (step_qual) begin
            if (presc_q == prescale_div) begin
                presc_d   = '0;
                step_fire = 1'b1;
            end else begin
                presc_d = presc_q + PRESCALE_BITS'(1);
            end
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    assign step_fire = step_qual;
`endif

    // Candidate count after one step in the current mode (modulo 2^NUM_CNT_BITS).
    always_comb begin
        step_val = count_q;
        case (mode)
            MODE_WRAP_UP:   step_val = (count_q >= rollover_val) ? CNT_ONE : count_q + CNT_ONE;
            MODE_WRAP_DOWN: step_val = (count_q <= CNT_ONE) ? rollover_val : count_q - CNT_ONE;
            // SAT_UP and ONE_SHOT both climb to rollover_val and hold there.
            default:        step_val = (count_q < rollover_val) ? count_q + CNT_ONE : count_q;
        endcase
    end

    // Next-state and output logic: clear > load > step; pulse is a single-cycle event.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        flag_d  = flag_q;
        pulse_d = 1'b0;
        if (clear) begin
            count_d = '0;
            flag_d  = 1'b0;
            state_d = ST_RUN;
        end else if (load) begin
            count_d = load_val;
            flag_d  = (load_val == terminal);
            state_d = ST_RUN;
        end else if (count_enable && (state_q == ST_RUN) && (rollover_val == '0)) begin
            // No terminal to count toward: count holds and the flag is dropped.
            flag_d = 1'b0;
        end else if (step_fire) begin
            count_d = step_val;
            flag_d  = (step_val == terminal);
            pulse_d = (step_val == terminal) && (count_q != terminal);
            if ((mode == MODE_ONE_SHOT) && (step_val == rollover_val)) begin
                state_d = ST_DONE;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_RUN;
            count_q <= '0;
            flag_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            flag_q  <= flag_d;
            pulse_q <= pulse_d;
        end
    end

    assign count_out      = count_q;
    assign rollover_flag  = flag_q;
    assign rollover_pulse = pulse_q;
    assign done           = (state_q == ST_DONE);

endmodule

// File: tb/tb_rcv_multimode_counter.sv
// Testbench for rcv_multimode_counter: directed scenarios plus randomized traffic against a reference model.
// Latency: outputs sampled 1 time unit after each rising edge; model advanced with the pre-edge inputs.
// Backpressure: not applicable; inputs are driven freely between edges.
module tb_rcv_multimode_counter;

    localparam int W  = 4;
`ifdef CNT_PRESCALE_EN
    localparam int PB = 3;
`endif

    logic          clk = 1'b0;
    logic          n_rst;
    logic          clear;
    logic          load;
    logic          count_enable;
    logic [1:0]    mode;
    logic [W-1:0]  load_val;
    logic [W-1:0]  rollover_val;
`ifdef CNT_PRESCALE_EN
    logic [PB-1:0] prescale_div;
`endif
    logic [W-1:0]  count_out;
    logic          rollover_flag;
    logic          rollover_pulse;
    logic          done;

    rcv_multimode_counter #(
        .NUM_CNT_BITS (W)
`ifdef CNT_PRESCALE_EN
        ,
        .PRESCALE_BITS(PB)
`endif
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (clear),
        .load          (load),
        .count_enable  (count_enable),
        .mode          (mode),
        .load_val      (load_val),
        .rollover_val  (rollover_val),
`ifdef CNT_PRESCALE_EN
        .prescale_div  (prescale_div),
`endif
        .count_out     (count_out),
        .rollover_flag (rollover_flag),
        .rollover_pulse(rollover_pulse),
        .done          (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: plain integers and booleans.
    int m_cnt   = 0;
    bit m_flag  = 1'b0;
    bit m_pulse = 1'b0;
    bit m_done  = 1'b0;
    int m_presc = 0;

    int seq_up  [12] = '{1, 2, 3, 4, 5, 1, 2, 3, 4, 5, 1, 2};
    int seq_dn  [6]  = '{2, 1, 4, 3, 2, 1};
    int seq_sat [6]  = '{1, 2, 3, 3, 3, 3};
    int seq_one [5]  = '{1, 2, 2, 2, 2};
    int done_one[5]  = '{0, 1, 1, 1, 1};
`ifdef CNT_PRESCALE_EN
    int seq_pre [9]  = '{0, 0, 1, 1, 1, 2, 2, 2, 3};
`endif

    task automatic expect_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want)
        else begin
            errors++;
            $error("FAIL %s got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic model_reset();
        m_cnt   = 0;
        m_flag  = 1'b0;
        m_pulse = 1'b0;
        m_done  = 1'b0;
        m_presc = 0;
    endtask

    // Apply the behavioural rules for one clock edge using the inputs currently driven.
    task automatic model_edge();
        int  md;
        int  r;
        int  lv;
        int  term;
        int  nxt;
        bit  fire;
        md   = int'(mode);
        r    = int'(rollover_val);
        lv   = int'(load_val);
        term = (md == 1) ? 1 : r;
        if (clear) begin
            model_reset();
        end else if (load) begin
            m_cnt   = lv;
            m_flag  = (lv == term);
            m_pulse = 1'b0;
            m_done  = 1'b0;
            m_presc = 0;
        end else begin
            m_pulse = 1'b0;
            if (count_enable && !m_done) begin
                if (r == 0) begin
                    m_flag = 1'b0;
                end else begin
                    fire = 1'b1;
`ifdef CNT_PRESCALE_EN
                    if (m_presc == int'(prescale_div)) begin
                        m_presc = 0;
                    end else begin
                        m_presc = (m_presc + 1) % (1 << PB);
                        fire = 1'b0;
                    end
`endif
                    if (fire) begin
                        if (md == 0)      nxt = (m_cnt >= r) ? 1 : m_cnt + 1;
                        else if (md == 1) nxt = (m_cnt <= 1) ? r : m_cnt - 1;
                        else              nxt = (m_cnt < r) ? m_cnt + 1 : m_cnt;
                        m_pulse = (nxt == term) && (m_cnt != term);
                        m_flag  = (nxt == term);
                        if (md == 3 && nxt == r) m_done = 1'b1;
                        m_cnt = nxt;
                    end
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        expect_val({tag, ".count"}, 32'(count_out),      32'(m_cnt));
        expect_val({tag, ".flag"},  32'(rollover_flag),  32'(m_flag));
        expect_val({tag, ".pulse"}, 32'(rollover_pulse), 32'(m_pulse));
        expect_val({tag, ".done"},  32'(done),           32'(m_done));
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic set_idle();
        clear        = 1'b0;
        load         = 1'b0;
        count_enable = 1'b0;
    endtask

    initial begin
        int pulses;
        n_rst        = 1'b0;
        clear        = 1'b0;
        load         = 1'b0;
        count_enable = 1'b0;
        mode         = 2'b00;
        load_val     = '0;
        rollover_val = '0;
`ifdef CNT_PRESCALE_EN
        prescale_div = '0;
`endif
        model_reset();
        #12;
        expect_val("reset.count", 32'(count_out),      32'd0);
        expect_val("reset.flag",  32'(rollover_flag),  32'd0);
        expect_val("reset.pulse", 32'(rollover_pulse), 32'd0);
        expect_val("reset.done",  32'(done),           32'd0);
        n_rst = 1'b1;

        // WRAP_UP, R=5, 12 enables from reset.
        mode = 2'b00; rollover_val = 4'd5; count_enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle("wrap_up");
            expect_val("wrap_up.seq",  32'(count_out),     32'(seq_up[i]));
            expect_val("wrap_up.flag", 32'(rollover_flag), (seq_up[i] == 5) ? 32'd1 : 32'd0);
        end

        // WRAP_DOWN, load 3, R=4, 6 enables.
        set_idle();
        load = 1'b1; load_val = 4'd3; rollover_val = 4'd4; mode = 2'b01;
        cycle("down_load");
        expect_val("down_load.count", 32'(count_out), 32'd3);
        set_idle();
        count_enable = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            cycle("wrap_down");
            expect_val("wrap_down.seq",  32'(count_out),     32'(seq_dn[i]));
            expect_val("wrap_down.flag", 32'(rollover_flag), (seq_dn[i] == 1) ? 32'd1 : 32'd0);
            pulses += int'(rollover_pulse);
        end
        expect_val("wrap_down.pulses", 32'(pulses), 32'd2);

        // SAT_UP, R=3, 6 enables, then raise R to 5.
        set_idle();
        clear = 1'b1;
        cycle("sat_clear");
        set_idle();
        mode = 2'b10; rollover_val = 4'd3; count_enable = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            cycle("sat_up");
            expect_val("sat_up.seq", 32'(count_out), 32'(seq_sat[i]));
            pulses += int'(rollover_pulse);
        end
        expect_val("sat_up.pulses", 32'(pulses), 32'd1);
        expect_val("sat_up.flag", 32'(rollover_flag), 32'd1);
        rollover_val = 4'd5;
        cycle("sat_raise");
        expect_val("sat_raise.seq4", 32'(count_out), 32'd4);
        cycle("sat_raise");
        expect_val("sat_raise.seq5", 32'(count_out), 32'd5);

        // ONE_SHOT, R=2, 5 enables; load 0 re-arms.
        set_idle();
        clear = 1'b1;
        cycle("one_clear");
        set_idle();
        mode = 2'b11; rollover_val = 4'd2; count_enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle("one_shot");
            expect_val("one_shot.seq",  32'(count_out), 32'(seq_one[i]));
            expect_val("one_shot.done", 32'(done),      32'(done_one[i]));
        end
        load = 1'b1; load_val = 4'd0;
        cycle("one_reload");
        expect_val("one_reload.done", 32'(done), 32'd0);
        load = 1'b0;
        cycle("one_resume");
        expect_val("one_resume.count", 32'(count_out), 32'd1);

        // clear+load+enable together at count 4, then async reset mid-count.
        set_idle();
        clear = 1'b1;
        cycle("prio_clear");
        set_idle();
        mode = 2'b00; rollover_val = 4'd9; count_enable = 1'b1;
        for (int i = 0; i < 4; i++) cycle("prio_count");
        expect_val("prio.at4", 32'(count_out), 32'd4);
        clear = 1'b1; load = 1'b1; load_val = 4'd7;
        cycle("prio_all");
        expect_val("prio_all.count", 32'(count_out),     32'd0);
        expect_val("prio_all.flag",  32'(rollover_flag), 32'd0);
        expect_val("prio_all.done",  32'(done),          32'd0);
        clear = 1'b0; load = 1'b0;
        for (int i = 0; i < 3; i++) cycle("pre_rst");
        #2;
        n_rst = 1'b0;
        #1;
        model_reset();
        expect_val("async_rst.count", 32'(count_out),      32'd0);
        expect_val("async_rst.flag",  32'(rollover_flag),  32'd0);
        expect_val("async_rst.pulse", 32'(rollover_pulse), 32'd0);
        expect_val("async_rst.done",  32'(done),           32'd0);
        count_enable = 1'b0;
        #3;
        n_rst = 1'b1;
        cycle("post_rst");

        // rollover_val==0 suppresses steps and drops the flag.
        rollover_val = 4'd3; count_enable = 1'b1;
        for (int i = 0; i < 3; i++) cycle("zero_r_setup");
        rollover_val = 4'd0;
        cycle("zero_r");
        expect_val("zero_r.count", 32'(count_out),     32'd3);
        expect_val("zero_r.flag",  32'(rollover_flag), 32'd0);

`ifdef CNT_PRESCALE_EN
        // Prescaler: div=2, WRAP_UP R=3, steps land on enables 3, 6 and 9.
        set_idle();
        clear = 1'b1;
        cycle("pre_clear");
        set_idle();
        prescale_div = 3'd2; mode = 2'b00; rollover_val = 4'd3; count_enable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cycle("prescale");
            expect_val("prescale.seq", 32'(count_out), 32'(seq_pre[i]));
        end
        prescale_div = '0;
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            clear        = ($urandom % 20) == 0;
            load         = ($urandom % 12) == 0;
            count_enable = ($urandom % 4) != 0;
            load_val     = W'($urandom % 16);
            if (($urandom % 16) == 0) mode = 2'($urandom % 4);
            if (($urandom % 10) == 0) rollover_val = W'($urandom % 16);
`ifdef CNT_PRESCALE_EN
            if (($urandom % 30) == 0) prescale_div = PB'($urandom % 4);
`endif
            cycle("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
